// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter (USB loader m0, conv engine m1) in front of one SDRAM slave port.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous contests; otherwise m0 always wins.
module sdram_wb_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          CLKOUT,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [3:0]    m0_sel,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_stall,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [3:0]    m1_sel,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic [DW-1:0] m1_rdata,
    output logic          cyc_i,
    output logic          stb_i,
    output logic          we_i,
    output logic [3:0]    sel_i,
    output logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_i,
    input  logic [DW-1:0] data_o,
    input  logic          stall_o,
    input  logic          sdram_ack,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StG0, StG1, StTurn} state_e;

    state_e     state_q, state_d;
    logic       last_served_q, last_served_d;
    logic [1:0] grant_q, grant_d;
    logic       m0_wins;

`ifdef ARB_ROUND_ROBIN_EN
    // last_served_q == 1 means m1 was served last, so m0 gets the next contest.
    assign m0_wins = last_served_q;
`else
    assign m0_wins = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = m0_wins ? StG0 : StG1;
                end else if (m0_cyc) begin
                    state_d = StG0;
                end else if (m1_cyc) begin
                    state_d = StG1;
                end
            end
            StG0: begin
                if (!m0_cyc) begin
                    state_d       = StTurn;
                    last_served_d = 1'b0;
                end
            end
            StG1: begin
                if (!m1_cyc) begin
                    state_d       = StTurn;
                    last_served_d = 1'b1;
                end
            end
            StTurn: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        grant_d = 2'b00;
        if (state_d == StG0) begin
            grant_d = 2'b01;
        end else if (state_d == StG1) begin
            grant_d = 2'b10;
        end
    end

    always_ff @(posedge CLKOUT) begin
        if (rst) begin
            state_q       <= StIdle;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            grant_q       <= grant_d;
        end
    end

    // Slave-side mux and response routing; only the granted master sees the slave.
    always_comb begin
        cyc_i    = 1'b0;
        stb_i    = 1'b0;
        we_i     = 1'b0;
        sel_i    = '0;
        addr_i   = '0;
        data_i   = '0;
        m0_ack   = 1'b0;
        m0_stall = 1'b1;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_stall = 1'b1;
        m1_rdata = '0;
        if (state_q == StG0) begin
            cyc_i    = m0_cyc;
            stb_i    = m0_cyc & m0_stb;
            we_i     = m0_we;
            sel_i    = m0_sel;
            addr_i   = m0_addr;
            data_i   = m0_wdata;
            m0_ack   = sdram_ack;
            m0_stall = stall_o;
            m0_rdata = data_o;
        end else if (state_q == StG1) begin
            cyc_i    = m1_cyc;
            stb_i    = m1_cyc & m1_stb;
            we_i     = m1_we;
            sel_i    = m1_sel;
            addr_i   = m1_addr;
            data_i   = m1_wdata;
            m1_ack   = sdram_ack;
            m1_stall = stall_o;
            m1_rdata = data_o;
        end
    end

    assign grant = grant_q;
    assign busy  = |grant_q;

endmodule

// File: doc/sdram_wb_arbiter.md
SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 32, address width; DW, 32, data width.
REQ-002 CLKOUT  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous to CLKOUT, active-high.
REQ-004 m0_cyc, m0_stb, m0_we  input  1 each  master 0 (USB loader) bus cycle, strobe, write-enable.
REQ-005 m0_sel  input  4; m0_addr  input  AW; m0_wdata  input  DW  master 0 byte selects, address, write data.
REQ-006 m0_ack, m0_stall  output  1 each; m0_rdata  output  DW  master 0 acknowledge, stall, read data.
REQ-007 m1_* SHALL mirror REQ-004..006 exactly, for master 1 (conv engine).
REQ-008 cyc_i, stb_i, we_i  output  1 each; sel_i  output  4; addr_i  output  AW; data_i  output  DW  SDRAM-side Wishbone request.
REQ-009 data_o  input  DW; stall_o  input  1; sdram_ack  input  1  SDRAM-side response.
REQ-010 grant  output  2  one-hot owner (01 = m0, 10 = m1, 00 = none); busy  output  1  grant != 00.

Function
REQ-011 The FSM SHALL have states IDLE, G0, G1 and TURN, held in a registered state variable.
REQ-012 In IDLE, if only mX_cyc=1, the next state SHALL be GX.
REQ-013 In IDLE with both cyc high, the winner SHALL follow REQ-030/031.
REQ-014 In IDLE with neither cyc high, the FSM SHALL remain in IDLE.
REQ-015 In GX the grant SHALL hold while mX_cyc=1, regardless of the other master.
REQ-016 In GX, when mX_cyc=0 is sampled, the next state SHALL be TURN, and last_served SHALL be set to X.
REQ-017 TURN SHALL last exactly one cycle, then go to IDLE; cyc_i SHALL be 0 in TURN and IDLE so that the slave returns to its wait state.
REQ-018 grant SHALL be registered (01 in G0, 10 in G1, else 00).
REQ-019 SDRAM-side outputs SHALL be a combinational mux of the granted master's signals: cyc_i = mX_cyc and stb_i = mX_stb while in GX; else cyc_i = stb_i = we_i = 0, sel_i = 0, addr_i = 0, data_i = 0.
REQ-020 The granted master SHALL receive mX_ack = sdram_ack, mX_stall = stall_o and mX_rdata = data_o.
REQ-021 A non-granted master SHALL see mX_ack=0, mX_stall=1 and mX_rdata=0.
REQ-022 A sdram_ack arriving outside G0/G1 SHALL be ignored and not forwarded.
REQ-023 Grant-to-SDRAM-cyc latency SHALL be 1 cycle from the request's cyc rising (IDLE->GX edge).
REQ-024 Minimum gap between two consecutive grants SHALL be 2 cycles (TURN + IDLE).
REQ-025 If the granted master drops cyc in the same cycle the other raises cyc, the FSM SHALL still pass through TURN and IDLE, then grant the other master.
REQ-026 mX_stb asserted without mX_cyc SHALL be ignored.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be IDLE, grant=00, busy=0 and last_served=1 (so m0 wins the first contest).
REQ-028 After reset, all SDRAM-side outputs SHALL be 0 and m0_ack=m1_ack=0, m0_stall=m1_stall=1.
REQ-029 Reset asserted mid-transfer SHALL force cyc_i=0 from the following cycle; no ack from the aborted transfer SHALL be forwarded.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, a simultaneous contest in IDLE SHALL be won by the master that is not last_served.
REQ-031 Without ARB_ROUND_ROBIN_EN, m0 SHALL always win a simultaneous contest; last_served is still maintained but SHALL not affect arbitration.

Verification
REQ-032 m0 only: m0_cyc=stb=we=1, addr=5, wdata=32'hA5A5_0001 -> grant=01 next cycle; cyc_i=1, addr_i=5; sdram_ack forwarded to m0_ack after the slave's 4-cycle strobe phase; m1_ack stays 0.
REQ-033 Both raise cyc on the same cycle after reset -> grant=01 with and without the macro.
REQ-034 Repeat the contest after m0 releases -> with ARB_ROUND_ROBIN_EN, grant=10; without it, grant=01.
REQ-035 m1 read of addr 7 (preloaded 32'h0000_0077) while m0 requests -> m1_rdata=32'h77 with m1_ack=1; m0_stall=1 throughout; m0 is granted exactly 2 cycles after m1_cyc falls.
REQ-036 rst pulsed for 1 cycle during a G0 write -> cyc_i=0, grant=00 next cycle; no m0_ack; the FSM restarts from IDLE.
REQ-037 sdram_ack forced to 1 in IDLE -> m0_ack=m1_ack=0.
